// File: rtl/symbol_period.sv
// symbol_period: one level of the symbol-counting game.
// Shows the level's magic glyph, then flashes a pseudo-random glyph sequence
// on a 4-digit active-low 7-seg display, one glyph per Clk1Hz strobe, and
// tallies how often the magic glyph appears. Ends with a one-cycle postSig.
// Optional build macro SYM_BLANK_GAP_EN: inserts a blank strobe slot after
// every shown glyph so consecutive identical glyphs are visually distinct.
module symbol_period #(
    parameter int unsigned BASE_SYMS      = 8,
    parameter int unsigned SYMS_PER_LEVEL = 4,
    parameter int unsigned MAGIC_TICKS    = 2,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       Clk100M,
    input  logic       Rst_n,
    input  logic       Clk1Hz,
    input  logic       startSig,
    input  logic [3:0] level,
    output logic       busy,
    output logic       postSig,
    output logic [7:0] magicSymbolCount,
    output logic [7:0] symSeg0,
    output logic [7:0] symSeg1,
    output logic [7:0] symSeg2,
    output logic [7:0] symSeg3
);

    typedef enum logic [1:0] {IDLE, SHOW_MAGIC, RUN, DONE} state_t;

`ifdef SYM_BLANK_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    localparam logic [15:0] MAGIC_LAST = 16'(MAGIC_TICKS - 1);

    state_t          r_state,  w_state_nxt;
    logic [15:0]     r_lfsr;
    logic            w_lfsr_fb;
    logic [2:0]      r_magic,  w_magic_nxt;
    logic [7:0]      r_total,  w_total_nxt;
    logic [7:0]      r_count,  w_count_nxt;
    logic [7:0]      r_shown,  w_shown_nxt;
    logic [15:0]     r_tick,   w_tick_nxt;
    logic [3:0][7:0] r_seg,    w_seg_nxt;
    logic            r_post,   w_post_nxt;
    logic [7:0]      r_mcount, w_mcount_nxt;
    logic            r_gap,    w_gap_nxt;
    logic [31:0]     w_total_raw;
    logic [7:0]      w_total_sat;

    function automatic logic [7:0] glyph(input logic [2:0] idx);
        case (idx)
            3'd0:    glyph = 8'hC0;
            3'd1:    glyph = 8'hF9;
            3'd2:    glyph = 8'hA4;
            3'd3:    glyph = 8'hB0;
            3'd4:    glyph = 8'h99;
            3'd5:    glyph = 8'h92;
            3'd6:    glyph = 8'h82;
            default: glyph = 8'hF8;
        endcase
    endfunction

    assign w_total_raw = BASE_SYMS + 32'(level) * SYMS_PER_LEVEL;
    assign w_total_sat = (w_total_raw > 32'd255) ? 8'hFF : w_total_raw[7:0];
    assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Free-running LFSR so the start instant randomises the sequence
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) r_lfsr <= LFSR_SEED;
        else        r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end

    // Next-state and registered-output computation
    always_comb begin
        w_state_nxt  = r_state;
        w_magic_nxt  = r_magic;
        w_total_nxt  = r_total;
        w_count_nxt  = r_count;
        w_shown_nxt  = r_shown;
        w_tick_nxt   = r_tick;
        w_seg_nxt    = r_seg;
        w_post_nxt   = 1'b0;
        w_mcount_nxt = r_mcount;
        w_gap_nxt    = r_gap;
        case (r_state)
            IDLE: begin
                if (startSig) begin
                    w_magic_nxt = r_lfsr[2:0];
                    w_total_nxt = w_total_sat;
                    w_count_nxt = '0;
                    w_shown_nxt = '0;
                    w_tick_nxt  = '0;
                    w_gap_nxt   = 1'b0;
                    w_seg_nxt   = {4{glyph(r_lfsr[2:0])}};
                    w_state_nxt = SHOW_MAGIC;
                end
            end
            SHOW_MAGIC: begin
                if (Clk1Hz) begin
                    if (r_tick == MAGIC_LAST) begin
                        w_seg_nxt   = '1;
                        w_state_nxt = RUN;
                    end else begin
                        w_tick_nxt = r_tick + 16'd1;
                    end
                end
            end
            RUN: begin
                if (Clk1Hz) begin
                    if (r_gap) begin
                        w_seg_nxt = '1;
                        w_gap_nxt = 1'b0;
                    end else if (r_shown == r_total) begin
                        w_seg_nxt    = '1;
                        w_post_nxt   = 1'b1;
                        w_mcount_nxt = r_count;
                        w_state_nxt  = DONE;
                    end else begin
                        w_seg_nxt                = '1;
                        w_seg_nxt[r_lfsr[4:3]]   = glyph(r_lfsr[2:0]);
                        w_shown_nxt              = r_shown + 8'd1;
                        w_gap_nxt                = GAP_EN;
                        if ((r_lfsr[2:0] == r_magic) && (r_count != 8'hFF))
                            w_count_nxt = r_count + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= IDLE;
            r_magic  <= '0;
            r_total  <= '0;
            r_count  <= '0;
            r_shown  <= '0;
            r_tick   <= '0;
            r_seg    <= '1;
            r_post   <= 1'b0;
            r_mcount <= '0;
            r_gap    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_magic  <= w_magic_nxt;
            r_total  <= w_total_nxt;
            r_count  <= w_count_nxt;
            r_shown  <= w_shown_nxt;
            r_tick   <= w_tick_nxt;
            r_seg    <= w_seg_nxt;
            r_post   <= w_post_nxt;
            r_mcount <= w_mcount_nxt;
            r_gap    <= w_gap_nxt;
        end
    end

    assign busy             = (r_state != IDLE);
    assign postSig          = r_post;
    assign magicSymbolCount = r_mcount;
    assign symSeg0          = r_seg[0];
    assign symSeg1          = r_seg[1];
    assign symSeg2          = r_seg[2];
    assign symSeg3          = r_seg[3];

endmodule

// File: tb/tb_symbol_period.sv
// Directed bench for symbol_period: default instance plus a saturating
// instance (SYMS_PER_LEVEL=20); an LFSR reference predicts every glyph.
module tb_symbol_period;

    localparam int MT = 2;

    logic       Clk100M = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Clk1Hz = 1'b0;
    logic       startSig = 1'b0;
    logic [3:0] level = 4'd0;
    logic       startSig2 = 1'b0;
    logic [3:0] level2 = 4'd0;

    logic       busy1, post1, busy2, post2;
    logic [7:0] cnt1, cnt2;
    logic [7:0] s10, s11, s12, s13, s20, s21, s22, s23;

    logic       dsel = 1'b0;
    logic       o_busy, o_post;
    logic [7:0] o_cnt;
    logic [7:0] o_seg [4];

    logic [15:0] m_lfsr;
    logic [2:0]  exp_magic;
    bit          r_early_post;
    int          n_tests = 0;
    int          n_fail = 0;

    symbol_period u_dut (
        .Clk100M(Clk100M), .Rst_n(Rst_n), .Clk1Hz(Clk1Hz),
        .startSig(startSig), .level(level),
        .busy(busy1), .postSig(post1), .magicSymbolCount(cnt1),
        .symSeg0(s10), .symSeg1(s11), .symSeg2(s12), .symSeg3(s13)
    );

    symbol_period #(.SYMS_PER_LEVEL(20)) u_dut_sat (
        .Clk100M(Clk100M), .Rst_n(Rst_n), .Clk1Hz(Clk1Hz),
        .startSig(startSig2), .level(level2),
        .busy(busy2), .postSig(post2), .magicSymbolCount(cnt2),
        .symSeg0(s20), .symSeg1(s21), .symSeg2(s22), .symSeg3(s23)
    );

    always #5 Clk100M = ~Clk100M;

    // Reference LFSR: Fibonacci, taps 16,14,13,11
    always @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    // Select which instance the scenario tasks observe
    always_comb begin
        o_busy   = dsel ? busy2 : busy1;
        o_post   = dsel ? post2 : post1;
        o_cnt    = dsel ? cnt2  : cnt1;
        o_seg[0] = dsel ? s20 : s10;
        o_seg[1] = dsel ? s21 : s11;
        o_seg[2] = dsel ? s22 : s12;
        o_seg[3] = dsel ? s23 : s13;
    end

    function automatic logic [7:0] glyph(input logic [2:0] idx);
        case (idx)
            3'd0:    glyph = 8'hC0;
            3'd1:    glyph = 8'hF9;
            3'd2:    glyph = 8'hA4;
            3'd3:    glyph = 8'hB0;
            3'd4:    glyph = 8'h99;
            3'd5:    glyph = 8'h92;
            3'd6:    glyph = 8'h82;
            default: glyph = 8'hF8;
        endcase
    endfunction

    task automatic idle(input int n, input bit inj);
        for (int c = 0; c < n; c++) begin
            if (inj && c == 1) begin
                if (dsel) startSig2 = 1'b1;
                else      startSig  = 1'b1;
            end
            @(negedge Clk100M);
            startSig  = 1'b0;
            startSig2 = 1'b0;
            if (o_post !== 1'b0) r_early_post = 1'b1;
        end
    endtask

    task automatic strobe(output logic [15:0] l);
        Clk1Hz = 1'b1;
        l = m_lfsr;
        @(negedge Clk100M);
        Clk1Hz = 1'b0;
    endtask

    task automatic start_level(input logic [3:0] lv, input bit with_strobe);
        @(negedge Clk100M);
        if (dsel) begin level2 = lv; startSig2 = 1'b1; end
        else      begin level  = lv; startSig  = 1'b1; end
        Clk1Hz = with_strobe;
        exp_magic = m_lfsr[2:0];
        r_early_post = 1'b0;
        @(negedge Clk100M);
        startSig = 1'b0; startSig2 = 1'b0; Clk1Hz = 1'b0;
    endtask

    // Drives magic phase, total glyphs and the closing strobe; ends one
    // cycle after the closing strobe, where postSig must be high.
    task automatic run_body(input int total, input int spacing, input bit inj,
                            output int exp_cnt, output int shown, output int seg_errs);
        logic [15:0] l;
        logic [7:0]  want;
        logic [7:0]  prev [4];
        int          nb;
        exp_cnt = 0; shown = 0; seg_errs = 0;
        for (int k = 0; k < MT; k++) begin
            idle(spacing - 1, 1'b0);
            strobe(l);
        end
        for (int d = 0; d < 4; d++) begin
            if (o_seg[d] !== 8'hFF) seg_errs++;
            prev[d] = 8'hFF;
        end
        for (int i = 0; i < total; i++) begin
            idle(spacing - 1, inj);
            for (int d = 0; d < 4; d++) if (o_seg[d] !== prev[d]) seg_errs++;
            strobe(l);
            nb = 0;
            for (int d = 0; d < 4; d++) begin
                want = (d == int'(l[4:3])) ? glyph(l[2:0]) : 8'hFF;
                if (o_seg[d] !== want) seg_errs++;
                if (o_seg[d] !== 8'hFF) nb++;
                prev[d] = want;
            end
            if (nb == 1) shown++;
            if (l[2:0] == exp_magic && exp_cnt < 255) exp_cnt++;
        end
        idle(spacing - 1, 1'b0);
        strobe(l);
    endtask

    task automatic test_reset;
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk100M);
        Rst_n = 1'b1;
        @(negedge Clk100M);
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if (o_seg[d] !== 8'hFF) begin
                $display("FAIL reset_seg%0d: got %h expected ff", d, o_seg[d]); n_fail++;
            end
        end
        n_tests++;
        if (o_busy !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", o_busy); n_fail++; end
        n_tests++;
        if (o_post !== 1'b0) begin $display("FAIL reset_post: got %b expected 0", o_post); n_fail++; end
        n_tests++;
        if (o_cnt !== 8'd0) begin $display("FAIL reset_count: got %0d expected 0", o_cnt); n_fail++; end
    endtask

    task automatic test_level0;
        int ec, sh, se;
        dsel = 1'b0;
        start_level(4'd0, 1'b0);
        n_tests++;
        if (o_busy !== 1'b1) begin $display("FAIL l0_busy: got %b expected 1", o_busy); n_fail++; end
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if (o_seg[d] !== glyph(exp_magic)) begin
                $display("FAIL l0_magic_seg%0d: got %h expected %h", d, o_seg[d], glyph(exp_magic)); n_fail++;
            end
        end
        run_body(8, 100, 1'b0, ec, sh, se);
        n_tests++;
        if (o_post !== 1'b1) begin $display("FAIL l0_post: got %b expected 1", o_post); n_fail++; end
        n_tests++;
        if (r_early_post) begin $display("FAIL l0_early_post: got 1 expected 0"); n_fail++; end
        n_tests++;
        if (o_cnt !== 8'(ec)) begin $display("FAIL l0_count: got %0d expected %0d", o_cnt, ec); n_fail++; end
        n_tests++;
        if (se != 0) begin $display("FAIL l0_segs: got %0d errors expected 0", se); n_fail++; end
        @(negedge Clk100M);
        n_tests++;
        if (o_post !== 1'b0) begin $display("FAIL l0_post_width: got %b expected 0", o_post); n_fail++; end
        n_tests++;
        if (o_busy !== 1'b0) begin $display("FAIL l0_idle_busy: got %b expected 0", o_busy); n_fail++; end
    endtask

    task automatic test_level3;
        int  ec, sh, se;
        bit  moved;
        dsel = 1'b0;
        start_level(4'd3, 1'b0);
        run_body(20, 100, 1'b0, ec, sh, se);
        n_tests++;
        if (o_post !== 1'b1) begin $display("FAIL l3_post: got %b expected 1", o_post); n_fail++; end
        n_tests++;
        if (sh != 20) begin $display("FAIL l3_shown: got %0d expected 20", sh); n_fail++; end
        n_tests++;
        if (se != 0) begin $display("FAIL l3_segs: got %0d errors expected 0", se); n_fail++; end
        n_tests++;
        if (o_cnt !== 8'(ec)) begin $display("FAIL l3_count: got %0d expected %0d", o_cnt, ec); n_fail++; end
        moved = 1'b0;
        repeat (1000) begin
            @(negedge Clk100M);
            if (o_cnt !== 8'(ec)) moved = 1'b1;
        end
        n_tests++;
        if (moved) begin $display("FAIL l3_count_hold: got changed expected %0d held", ec); n_fail++; end
    endtask

    task automatic test_saturation;
        int ec, sh, se;
        dsel = 1'b1;
        start_level(4'd15, 1'b0);
        run_body(255, 10, 1'b0, ec, sh, se);
        n_tests++;
        if (o_post !== 1'b1) begin $display("FAIL sat_post: got %b expected 1", o_post); n_fail++; end
        n_tests++;
        if (r_early_post) begin $display("FAIL sat_early_post: got 1 expected 0"); n_fail++; end
        n_tests++;
        if (sh != 255) begin $display("FAIL sat_shown: got %0d expected 255", sh); n_fail++; end
        n_tests++;
        if (se != 0) begin $display("FAIL sat_segs: got %0d errors expected 0", se); n_fail++; end
        n_tests++;
        if (o_cnt !== 8'(ec)) begin $display("FAIL sat_count: got %0d expected %0d", o_cnt, ec); n_fail++; end
        @(negedge Clk100M);
        dsel = 1'b0;
    endtask

    task automatic test_start_ignored;
        int ec, sh, se;
        dsel = 1'b0;
        start_level(4'd1, 1'b0);
        level = 4'd0;
        run_body(12, 50, 1'b1, ec, sh, se);
        n_tests++;
        if (o_post !== 1'b1) begin $display("FAIL ign_post: got %b expected 1", o_post); n_fail++; end
        n_tests++;
        if (r_early_post) begin $display("FAIL ign_early_post: got 1 expected 0"); n_fail++; end
        n_tests++;
        if (sh != 12 || se != 0) begin
            $display("FAIL ign_sequence: got shown=%0d errs=%0d expected shown=12 errs=0", sh, se); n_fail++;
        end
        n_tests++;
        if (o_cnt !== 8'(ec)) begin $display("FAIL ign_count: got %0d expected %0d", o_cnt, ec); n_fail++; end
        @(negedge Clk100M);
    endtask

    task automatic test_start_with_strobe;
        int ec, sh, se;
        dsel = 1'b0;
        start_level(4'd0, 1'b1);
        run_body(8, 50, 1'b0, ec, sh, se);
        n_tests++;
        if (o_post !== 1'b1) begin $display("FAIL coin_post: got %b expected 1", o_post); n_fail++; end
        n_tests++;
        if (r_early_post) begin $display("FAIL coin_early_post: got 1 expected 0"); n_fail++; end
        n_tests++;
        if (se != 0) begin $display("FAIL coin_segs: got %0d errors expected 0", se); n_fail++; end
        @(negedge Clk100M);
    endtask

    task automatic test_reset_mid_run;
        logic [15:0] l;
        int ec, sh, se;
        dsel = 1'b0;
        start_level(4'd3, 1'b0);
        repeat (MT + 3) begin
            idle(9, 1'b0);
            strobe(l);
        end
        Rst_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if (o_seg[d] !== 8'hFF) begin
                $display("FAIL rst_mid_seg%0d: got %h expected ff", d, o_seg[d]); n_fail++;
            end
        end
        n_tests++;
        if (o_busy !== 1'b0 || o_post !== 1'b0 || o_cnt !== 8'd0) begin
            $display("FAIL rst_mid_outputs: got busy=%b post=%b cnt=%0d expected 0 0 0", o_busy, o_post, o_cnt);
            n_fail++;
        end
        @(negedge Clk100M);
        Rst_n = 1'b1;
        r_early_post = 1'b0;
        repeat (30) begin
            idle(9, 1'b0);
            strobe(l);
            if (o_post !== 1'b0) r_early_post = 1'b1;
        end
        n_tests++;
        if (r_early_post || o_busy !== 1'b0) begin
            $display("FAIL rst_mid_no_post: got post_seen=%b busy=%b expected 0 0", r_early_post, o_busy);
            n_fail++;
        end
        start_level(4'd0, 1'b0);
        run_body(8, 20, 1'b0, ec, sh, se);
        n_tests++;
        if (o_post !== 1'b1) begin $display("FAIL rst_fresh_post: got %b expected 1", o_post); n_fail++; end
        n_tests++;
        if (o_cnt !== 8'(ec) || se != 0) begin
            $display("FAIL rst_fresh_run: got cnt=%0d errs=%0d expected cnt=%0d errs=0", o_cnt, se, ec);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_level0();
        test_level3();
        test_saturation();
        test_start_ignored();
        test_start_with_strobe();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
